sc_data_fifo: RTL and testbench



---
 rtl/sc_data_fifo_pkg.sv | 36 +++
 rtl/sc_data_buffer_mem.sv | 36 +++
 rtl/sc_data_fifo.sv | 110 +++++++++++
 tb/tb_sc_data_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sc_data_fifo_pkg.sv
// Shared definitions for the single-clock data FIFO: pointer-width helper,
// one-hot pointer rotation and the transfer-type encoding used by the top level.
package sc_data_fifo_pkg;

  localparam int unsigned MAX_DEPTH = 1024;

  typedef enum logic [1:0] {
    XFER_IDLE = 2'b00,
    XFER_POP  = 2'b01,
    XFER_PUSH = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  // Ceiling log2; the emulation build leans on the tool's built-in.
  function automatic int unsigned sc_log2(input int unsigned n);
    int unsigned r;
    r = 0;
`ifdef PULP_FPGA_EMUL
    r = $clog2(n);
`else
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
`endif
    return r;
  endfunction

  // Rotate a one-hot pointer of 'width' live bits left by one, wrapping the top bit to bit 0.
  function automatic logic [MAX_DEPTH-1:0] onehot_rotl(input logic [MAX_DEPTH-1:0] ptr,
                                                       input int unsigned width);
    logic [MAX_DEPTH-1:0] mask;
    mask = ~({MAX_DEPTH{1'b1}} << width);
    return ((ptr << 1) | (ptr >> (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/sc_data_buffer_mem.sv
// Storage array addressed by one-hot write/read pointers.
// Synchronous reset clears every entry so the read port shows zero after reset.
module sc_data_buffer_mem #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [BUFFER_DEPTH-1:0] i_wr_ptr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [BUFFER_DEPTH-1:0] i_rd_ptr,
  output logic [DATA_WIDTH-1:0]   o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        if (i_wr_ptr[i]) r_mem[i] <= i_wr_data;
      end
    end
  end

  // AND-OR read mux; the read pointer is one-hot so at most one term contributes.
  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      if (i_rd_ptr[i]) o_rd_data = o_rd_data | r_mem[i];
    end
  end

endmodule

// File: rtl/sc_data_fifo.sv
// Single-clock FIFO with valid/ready on both sides, occupancy count, almost-full,
// synchronous flush and an optional zero-latency bypass when empty.
module sc_data_fifo
  import sc_data_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned BUFFER_DEPTH = 8,
  parameter  int unsigned FALL_THROUGH = 0,
  parameter  int unsigned AFULL_LEVEL  = BUFFER_DEPTH - 1,
  localparam int unsigned CNT_WIDTH    = sc_log2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  almost_full
);

  localparam logic [CNT_WIDTH-1:0]    LP_DEPTH    = CNT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0]    LP_AFULL    = CNT_WIDTH'(AFULL_LEVEL);
  localparam logic [BUFFER_DEPTH-1:0] LP_PTR_INIT = BUFFER_DEPTH'(1);

  logic [BUFFER_DEPTH-1:0] r_wptr;
  logic [BUFFER_DEPTH-1:0] r_rptr;
  logic [CNT_WIDTH-1:0]    r_count;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_block;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  xfer_e                 w_xfer;

  function automatic logic [BUFFER_DEPTH-1:0] ptr_next(input logic [BUFFER_DEPTH-1:0] p);
    return BUFFER_DEPTH'(onehot_rotl(MAX_DEPTH'(p), BUFFER_DEPTH));
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);
  // Neither side may handshake while the FIFO is being cleared.
  assign w_block = rst | flush;

  assign in_ready = ~w_block & ~w_full;

  generate
    if (FALL_THROUGH != 0) begin : g_fall_through
      assign out_valid = ~w_block & (~w_empty | in_valid);
      assign out_data  = (w_empty & in_valid) ? in_data : w_mem_rdata;
      assign w_bypass  = w_empty & in_valid & out_ready & ~w_block;
    end else begin : g_registered
      assign out_valid = ~w_block & ~w_empty;
      assign out_data  = w_mem_rdata;
      assign w_bypass  = 1'b0;
    end
  endgenerate

  // A bypassed word is handed straight across, so it touches neither pointer nor storage.
  assign w_push = in_valid & in_ready & ~w_bypass;
  assign w_pop  = out_valid & out_ready & ~w_bypass;
  assign w_xfer = xfer_e'({w_push, w_pop});

  always_ff @(posedge clk) begin
    if (w_block) begin
      r_wptr  <= LP_PTR_INIT;
      r_rptr  <= LP_PTR_INIT;
      r_count <= '0;
    end else begin
      case (w_xfer)
        XFER_PUSH: begin
          r_wptr  <= ptr_next(r_wptr);
          r_count <= r_count + CNT_WIDTH'(1);
        end
        XFER_POP: begin
          r_rptr  <= ptr_next(r_rptr);
          r_count <= r_count - CNT_WIDTH'(1);
        end
        XFER_BOTH: begin
          r_wptr <= ptr_next(r_wptr);
          r_rptr <= ptr_next(r_rptr);
        end
        default: ;
      endcase
    end
  end

  sc_data_buffer_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_push),
    .i_wr_ptr (r_wptr),
    .i_wr_data(in_data),
    .i_rd_ptr (r_rptr),
    .o_rd_data(w_mem_rdata)
  );

  assign count       = r_count;
  assign almost_full = (r_count >= LP_AFULL);

endmodule

// File: tb/tb_sc_data_fifo.sv
// Scoreboard bench: one registered-output FIFO and one fall-through FIFO share the
// same stimulus; a queue-based model predicts flags and the order of popped words.
module tb_sc_data_fifo;

  localparam int DW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          ir0, ir1, ov0, ov1, af0, af1;
  logic [DW-1:0] od0, od1;
  logic [3:0]    co0, co1;

  int vectors = 0;
  int errors  = 0;
  bit armed   = 1'b0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int mcnt[2];
  int exp_cnt[2];
  bit exp_ir[2], exp_ov[2], exp_af[2];

  always #5 clk = ~clk;

  sc_data_fifo #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D), .FALL_THROUGH(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
    .count(co0), .almost_full(af0)
  );

  sc_data_fifo #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D), .FALL_THROUGH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
    .count(co1), .almost_full(af1)
  );

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model works purely in terms of occupancy and word order.
  task automatic cyc(input bit iv, input logic [DW-1:0] id, input bit ordy,
                     input bit fl, input bit rs);
    @(negedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    for (int k = 0; k < 2; k++) begin
      bit push, pop;
      exp_cnt[k] = mcnt[k];
      exp_af[k]  = (mcnt[k] >= D - 1);
      exp_ir[k]  = !rs && !fl && (mcnt[k] < D);
      exp_ov[k]  = !rs && !fl && ((mcnt[k] > 0) || (k == 1 && iv));
      push = iv && exp_ir[k];
      pop  = exp_ov[k] && ordy;
      if (push) begin
        if (k == 0) q0.push_back(id);
        else        q1.push_back(id);
      end
      if (rs || fl) begin
        mcnt[k] = 0;
        if (k == 0) q0.delete();
        else        q1.delete();
      end else begin
        mcnt[k] = mcnt[k] + int'(push) - int'(pop);
      end
    end
    armed = 1'b1;
  endtask

  task automatic to_count(input int n);
    for (int i = 0; i < 20 && mcnt[0] != n; i++)
      cyc(mcnt[0] < n, $urandom, mcnt[0] > n, 1'b0, 1'b0);
  endtask

  // Monitor: checks flags every cycle and pops the scoreboard on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          logic [DW-1:0] want;
          cmp($sformatf("in_ready%0d", k),    32'(k == 0 ? ir0 : ir1), 32'(exp_ir[k]));
          cmp($sformatf("out_valid%0d", k),   32'(k == 0 ? ov0 : ov1), 32'(exp_ov[k]));
          cmp($sformatf("count%0d", k),       32'(k == 0 ? co0 : co1), 32'(exp_cnt[k]));
          cmp($sformatf("almost_full%0d", k), 32'(k == 0 ? af0 : af1), 32'(exp_af[k]));
          if (exp_ov[k] && out_ready) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
              vectors++;
              errors++;
              $display("FAIL scoreboard%0d: pop with no expected word (t=%0t)", k, $time);
            end else begin
              if (k == 0) want = q0.pop_front();
              else        want = q1.pop_front();
              cmp($sformatf("out_data%0d", k), (k == 0) ? od0 : od1, want);
            end
          end
        end
      end
    end
  end

  initial begin
    mcnt = '{0, 0};
    void'($urandom(32'd7));
    repeat (2) @(negedge clk);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    cmp("reset_out_data", od0, '0);

    // Fill 0..7 with no consumer, try one more while full, then drain in order.
    for (int i = 0; i < D; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < D; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Random traffic holding occupancy in 1..7 so both pointers wrap.
    for (int i = 0; i < 60; i++)
      cyc(($urandom_range(0, 1) == 1) && mcnt[0] < 7, $urandom,
          ($urandom_range(0, 1) == 1) && mcnt[0] > 1, 1'b0, 1'b0);

    to_count(3);
    repeat (10) cyc(1'b1, $urandom, 1'b1, 1'b0, 1'b0);

    // Full corner: only the pop happens, then the held word goes in.
    to_count(8);
    cyc(1'b1, 32'hC0FFEE, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hC0FFEE, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    to_count(5);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    to_count(4);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    cmp("rst_midop_out_data", od0, '0);

    // Fall-through: bypass with a ready consumer, then a stored word without one.
    cyc(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
          $urandom_range(0, 31) == 0, 1'b0);

    repeat (10) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #6;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
